data_io_sync: RTL and testbench

//  Oversampled SPI slave to the MC2 io controller, run in the clk_sys domain.

---
 rtl/data_io_sync_pkg.sv | 21 ++
 rtl/data_io_sync_spi_sync_edge.sv | 39 +++
 rtl/data_io_sync.sv | 226 ++++++++++++++++++++++
 tb/tb_data_io_sync.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_io_sync_pkg.sv
// Shared command codes, reply constants and FSM state type for the io-controller SPI slave.
package data_io_pkg;

  localparam logic [7:0] CMD_ACK      = 8'h00;
  localparam logic [7:0] CMD_DATA     = 8'h10;
  localparam logic [7:0] CMD_CONFSTR  = 8'h14;
  localparam logic [7:0] CMD_STATUS   = 8'h15;
  localparam logic [7:0] CMD_INDEX    = 8'h55;
  localparam logic [7:0] CMD_CFG      = 8'h60;
  localparam logic [7:0] CMD_DL_START = 8'h61;
  localparam logic [7:0] CMD_DL_END   = 8'h62;

  localparam logic [7:0] ACK_BYTE = 8'h4B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD
  } spi_state_t;

endpackage

// File: rtl/data_io_sync_spi_sync_edge.sv
// Brings the asynchronous SPI pins into clk_sys: 2-FF synchronisers plus registered SCK edge pulses.
module spi_sync_edge (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic spi_sck,
  input  logic spi_ss2,
  input  logic spi_di,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss2,
  output logic di
);

  logic [2:0] sck_s;
  logic [1:0] ss_s;
  logic [1:0] di_s;

  // SS2 idles high, so its synchroniser resets high to avoid a phantom frame
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sck_s    <= '0;
      ss_s     <= 2'b11;
      di_s     <= '0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      di       <= 1'b0;
    end else begin
      sck_s    <= {sck_s[1:0], spi_sck};
      ss_s     <= {ss_s[0], spi_ss2};
      di_s     <= {di_s[0], spi_di};
      sck_rise <= sck_s[1] & ~sck_s[2];
      sck_fall <= ~sck_s[1] & sck_s[2];
      di       <= di_s[1];
    end
  end

  assign ss2 = ss_s[1];

endmodule

// File: rtl/data_io_sync.sv
// Oversampled SPI slave to the MC2 io controller: menu status, config bytes, string readback, ROM download.
//  state      | meaning
//  ST_IDLE    | SS2 high, no transfer in flight
//  ST_CMD     | SS2 low, shifting in the command byte
//  ST_PAYLOAD | command latched, further bytes are payload
module data_io_sync
  import data_io_pkg::*;
#(
  parameter int STRLEN    = 0,
  parameter int DW        = 8,
  parameter int AW        = 25,
  parameter int CFG_BYTES = 16
) (
  input  logic                                   clk_sys,
  input  logic                                   rst_n,
  input  logic                                   SPI_SCK,
  input  logic                                   SPI_SS2,
  input  logic                                   SPI_DI,
  output logic                                   SPI_DO,
  input  logic [7:0]                             data_in,
  input  logic [(STRLEN > 0 ? 8*STRLEN : 8)-1:0] conf_str,
  output logic [31:0]                            status,
  output logic [6:0]                             core_mod,
  output logic [8*CFG_BYTES-1:0]                 config_buffer,
  input  logic                                   ioctl_wait,
  output logic                                   ioctl_download,
  output logic [7:0]                             ioctl_index,
  output logic                                   ioctl_wr,
  output logic [AW-1:0]                          ioctl_addr,
  output logic [DW-1:0]                          ioctl_dout,
  output logic                                   ioctl_overrun
);

  localparam int NL  = DW / 8;
  localparam int NCH = (STRLEN > 0) ? STRLEN : 1;
  localparam int CW  = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
  localparam logic [CW-1:0] CFG_TOP   = CW'(CFG_BYTES - 1);
  localparam logic [1:0]    LAST_LANE = 2'(NL - 1);
  localparam logic [AW-1:0] ADDR_STEP = AW'(NL);

  logic       sck_rise, sck_fall, ss2, di;
  spi_state_t state_q, state_d;
  logic [2:0] bit_cnt;
  logic [9:0] byte_cnt, str_idx;
  logic [6:0] rx_sr;
  logic [7:0] rx_byte, cmd_q, tx_sr, resp;
  logic       rx_done, cmd_done, pay_done;
  logic [CW-1:0] cnf_idx;
  logic       cnf_done;

  logic [DW-1:0] asm_q, asm_next, push_data, dout_q;
  logic [AW-1:0] addr_q, waddr_q;
  logic [1:0]    lane_q;
  logic          pend_q, closing_q, word_done, flush, push, pend_free;

  spi_sync_edge u_sync (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .spi_sck  (SPI_SCK),
    .spi_ss2  (SPI_SS2),
    .spi_di   (SPI_DI),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss2      (ss2),
    .di       (di)
  );

  assign rx_byte  = {rx_sr, di};
  assign rx_done  = sck_rise & ~ss2 & (bit_cnt == 3'd7);
  assign cmd_done = rx_done & (state_q == ST_CMD);
  assign pay_done = rx_done & (state_q == ST_PAYLOAD);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (!ss2) state_d = ST_CMD;
      ST_CMD:     if (ss2) state_d = ST_IDLE;
                  else if (rx_done) state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (ss2) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Reply byte for the payload slot about to start; byte_cnt already counts the command byte
  always_comb begin
    resp    = 8'h00;
    str_idx = byte_cnt - 10'd1;
    case (cmd_q)
      CMD_ACK:  resp = ACK_BYTE;
      CMD_DATA: resp = data_in;
      CMD_CONFSTR:
        for (int i = 0; i < NCH; i++)
          if (STRLEN > 0 && str_idx == 10'(i)) resp = conf_str[8*(NCH-1-i) +: 8];
      default:  resp = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      cmd_q    <= '0;
    end else if (ss2) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_sr    <= '0;
    end else if (sck_rise) begin
      rx_sr   <= rx_byte[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7 && byte_cnt != '1) byte_cnt <= byte_cnt + 10'd1;
      if (cmd_done) cmd_q <= rx_byte;
    end else if (sck_fall) begin
      if (bit_cnt == 3'd0) tx_sr <= (state_q == ST_PAYLOAD) ? resp : 8'h00;
      else                 tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  assign SPI_DO = SPI_SS2 ? 1'bz : tx_sr[7];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      status        <= '0;
      core_mod      <= '0;
      ioctl_index   <= '0;
      config_buffer <= '0;
      cnf_idx       <= CFG_TOP;
      cnf_done      <= 1'b0;
    end else if (ss2) begin
      cnf_idx  <= CFG_TOP;
      cnf_done <= 1'b0;
    end else if (pay_done) begin
      case (cmd_q)
        CMD_STATUS:
          case (byte_cnt)
            10'd1:   status[31:24] <= rx_byte;
            10'd2:   status[23:16] <= rx_byte;
            10'd3:   status[15:8]  <= rx_byte;
            10'd4:   status[7:0]   <= rx_byte;
            10'd5:   core_mod      <= rx_byte[6:0];
            default: ;
          endcase
        CMD_INDEX: ioctl_index <= rx_byte;
        CMD_CFG:
          if (!cnf_done) begin
            for (int k = 0; k < CFG_BYTES; k++)
              if (cnf_idx == CW'(k)) config_buffer[8*k +: 8] <= rx_byte;
            if (cnf_idx == '0) cnf_done <= 1'b1;
            else               cnf_idx  <= cnf_idx - 1'b1;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < NL; k++)
      if (lane_q == 2'(k)) asm_next[8*k +: 8] = rx_byte;
  end

  assign word_done = pay_done & (cmd_q == CMD_DL_START) & ioctl_download & (lane_q == LAST_LANE);
  assign flush     = cmd_done & (rx_byte == CMD_DL_END) & ioctl_download & (lane_q != 2'd0);
  assign push      = word_done | flush;
  assign push_data = flush ? asm_q : asm_next;
  // A write accepted this very cycle frees the slot for an incoming word
  assign pend_free = ~pend_q | ~ioctl_wait;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ioctl_download <= 1'b0;
      ioctl_overrun  <= 1'b0;
      pend_q         <= 1'b0;
      closing_q      <= 1'b0;
      asm_q          <= '0;
      lane_q         <= '0;
      addr_q         <= '0;
      waddr_q        <= '0;
      dout_q         <= '0;
    end else begin
      if (pend_q && !ioctl_wait) pend_q <= 1'b0;

      if (push) begin
        if (pend_free) begin
          pend_q  <= 1'b1;
          dout_q  <= push_data;
          waddr_q <= addr_q;
        end else begin
          ioctl_overrun <= 1'b1;
        end
        addr_q <= addr_q + ADDR_STEP;
        lane_q <= '0;
        asm_q  <= '0;
      end else if (pay_done && cmd_q == CMD_DL_START && ioctl_download) begin
        asm_q  <= asm_next;
        lane_q <= lane_q + 2'd1;
      end

      if (cmd_done && rx_byte == CMD_DL_START) begin
        ioctl_download <= 1'b1;
        ioctl_overrun  <= 1'b0;
        closing_q      <= 1'b0;
        addr_q         <= '0;
        lane_q         <= '0;
        asm_q          <= '0;
      end else if (cmd_done && rx_byte == CMD_DL_END && ioctl_download) begin
        if (!flush && !pend_q) ioctl_download <= 1'b0;
        else                   closing_q      <= 1'b1;
      end else if (closing_q && !pend_q) begin
        ioctl_download <= 1'b0;
        closing_q      <= 1'b0;
      end
    end
  end

  assign ioctl_wr   = pend_q & ~ioctl_wait;
  assign ioctl_addr = waddr_q;
  assign ioctl_dout = dout_q;

endmodule

// File: tb/tb_data_io_sync.sv
// Directed/randomised bench for data_io_sync with a byte-level reference model of the SPI protocol.
module tb_data_io_sync;

  localparam int DW = 16, AW = 25, STRLEN = 3, CFG_BYTES = 16;

  logic clk_sys = 1'b0, rst_n = 1'b0;
  logic SPI_SCK = 1'b0, SPI_SS2 = 1'b1, SPI_DI = 1'b0;
  wire  SPI_DO;
  logic [7:0] data_in = 8'h00;
  logic [8*STRLEN-1:0] conf_str = "ABC";
  logic [31:0] status;
  logic [6:0] core_mod;
  logic [8*CFG_BYTES-1:0] config_buffer;
  logic ioctl_wait = 1'b0;
  logic ioctl_download, ioctl_wr, ioctl_overrun;
  logic [7:0] ioctl_index;
  logic [AW-1:0] ioctl_addr;
  logic [DW-1:0] ioctl_dout;

  data_io_sync #(.STRLEN(STRLEN), .DW(DW), .AW(AW), .CFG_BYTES(CFG_BYTES)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
    .SPI_DO(SPI_DO), .data_in(data_in), .conf_str(conf_str), .status(status), .core_mod(core_mod),
    .config_buffer(config_buffer), .ioctl_wait(ioctl_wait), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_overrun(ioctl_overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors = 0, errors = 0;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          dl;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  bq_t rx_q;
  logic [7:0] cfg_m[CFG_BYTES];

  always @(negedge clk_sys) if (ioctl_wr) got_q.push_back({ioctl_addr, ioctl_dout, ioctl_download});

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      SPI_DI = tx[i];
      repeat (8) @(negedge clk_sys);
      rx[i] = SPI_DO;
      SPI_SCK = 1'b1;
      repeat (8) @(negedge clk_sys);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic frame(input bq_t b);
    logic [7:0] r;
    rx_q.delete();
    SPI_SS2 = 1'b0;
    repeat (4) @(negedge clk_sys);
    foreach (b[i]) begin
      xfer_bits(b[i], 8, r);
      rx_q.push_back(r);
    end
    repeat (6) @(negedge clk_sys);
    SPI_SS2 = 1'b1;
    repeat (8) @(negedge clk_sys);
  endtask

  // Expected writes for an uninterrupted download: little-endian byte pairs, last odd byte zero-padded
  function automatic void model_dl(input bq_t b);
    exp_q.delete();
    for (int i = 0; i < b.size(); i += 2) begin
      wr_t w;
      w.addr = AW'(i);
      w.data = {(i + 1 < b.size()) ? b[i+1] : 8'h00, b[i]};
      w.dl   = 1'b1;
      exp_q.push_back(w);
    end
  endfunction

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, 128'(got_q[i]), 128'(exp_q[i]));
    got_q.delete();
  endtask

  task automatic run_download(input string tag, input bq_t body);
    bq_t f;
    f = body;
    f.push_front(8'h61);
    model_dl(body);
    frame(f);
    check({tag, "_dl_active"}, 128'(ioctl_download), 128'(1));
    frame('{8'h62});
    repeat (6) @(negedge clk_sys);
    check({tag, "_dl_done"}, 128'(ioctl_download), 128'(0));
    compare_writes(tag);
  endtask

  initial begin
    bq_t b;
    logic [7:0] r, last, w0, w1, w2, w3;
    logic [127:0] cfg_exp;
    int n, idx;

    foreach (cfg_m[k]) cfg_m[k] = 8'h00;
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    check("rst_status", 128'(status), 128'(0));
    check("rst_core_mod", 128'(core_mod), 128'(0));
    check("rst_cfg", 128'(config_buffer), 128'(0));
    check("rst_dl", 128'({ioctl_download, ioctl_wr, ioctl_overrun}), 128'(0));
    check("rst_index", 128'(ioctl_index), 128'(0));
    check("rst_addr_dout", 128'({ioctl_addr, ioctl_dout}), 128'(0));
    vectors++;
    assert (SPI_DO === 1'bz) else begin
      errors++;
      $error("FAIL rst_do_z: observed %b expected z", SPI_DO);
    end

    frame('{8'h00, 8'h00, 8'hA5});
    check("ack_byte0", 128'(rx_q[1]), 128'(8'h4B));
    check("ack_byte1", 128'(rx_q[2]), 128'(8'h4B));

    frame('{8'h15, 8'h12, 8'h34, 8'h56, 8'h78, 8'h05, 8'h99});
    check("status_fixed", 128'(status), 128'(32'h12345678));
    check("core_mod_fixed", 128'(core_mod), 128'(7'h05));
    b = '{8'h15};
    for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
    frame(b);
    check("status_rand", 128'(status), 128'({b[1], b[2], b[3], b[4]}));
    check("core_mod_rand", 128'(core_mod), 128'(b[5][6:0]));

    for (int t = 0; t < 2; t++) begin
      data_in = 8'($urandom);
      frame('{8'h10, 8'h00});
      check("data_in_echo", 128'(rx_q[1]), 128'(data_in));
    end

    frame('{8'h33, 8'hFF, 8'h00});
    check("unknown_do", 128'({rx_q[1], rx_q[2]}), 128'(0));
    check("unknown_no_effect", 128'(status), 128'({b[1], b[2], b[3], b[4]}));

    n = $urandom_range(1, 4);
    b = '{8'h55};
    for (int i = 0; i < n; i++) begin
      last = 8'($urandom);
      b.push_back(last);
    end
    frame(b);
    check("index_last", 128'(ioctl_index), 128'(last));

    for (int t = 0; t < 2; t++) begin
      n = (t == 0) ? 5 : 19;
      b = '{8'h60};
      idx = CFG_BYTES - 1;
      for (int i = 0; i < n; i++) begin
        r = 8'($urandom);
        b.push_back(r);
        if (idx >= 0) cfg_m[idx] = r;
        idx--;
      end
      frame(b);
      cfg_exp = '0;
      for (int k = 0; k < CFG_BYTES; k++) cfg_exp[8*k +: 8] = cfg_m[k];
      check("cfg_buffer", config_buffer, cfg_exp);
    end

    run_download("dl_even", '{8'hAA, 8'hBB, 8'hCC, 8'hDD});
    run_download("dl_pad", '{8'hAA, 8'hBB, 8'hCC});
    b.delete();
    n = $urandom_range(1, 9);
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    run_download("dl_rand", b);

    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
    @(posedge clk_sys); #1 ioctl_wait = 1'b1;
    frame('{8'h61, w0, w1, w2, w3});
    check("wait_no_wr", 128'(got_q.size()), 128'(0));
    check("wait_held", 128'({ioctl_addr, ioctl_dout}), 128'({25'd0, w1, w0}));
    check("wait_overrun", 128'(ioctl_overrun), 128'(1));
    @(posedge clk_sys); #1 ioctl_wait = 1'b0;
    repeat (4) @(negedge clk_sys);
    exp_q.delete();
    exp_q.push_back({25'd0, w1, w0, 1'b1});
    compare_writes("wait_release");
    frame('{8'h62});
    check("wait_dl_done", 128'(ioctl_download), 128'(0));
    check("overrun_sticky", 128'(ioctl_overrun), 128'(1));
    frame('{8'h61});
    check("overrun_clear", 128'(ioctl_overrun), 128'(0));
    frame('{8'h62});
    check("empty_dl_done", 128'(ioctl_download), 128'(0));
    check("empty_no_wr", 128'(got_q.size()), 128'(0));

    frame('{8'h14, 8'h00, 8'h00, 8'h00, 8'h00});
    check("confstr", 128'({rx_q[1], rx_q[2], rx_q[3], rx_q[4]}), 128'(32'h41424300));
    rx_q.delete();
    SPI_SS2 = 1'b0;
    repeat (4) @(negedge clk_sys);
    xfer_bits(8'h14, 8, r);
    xfer_bits(8'h00, 8, r);
    check("confstr_first", 128'(r), 128'(8'h41));
    xfer_bits(8'h00, 3, r);
    repeat (6) @(negedge clk_sys);
    SPI_SS2 = 1'b1;
    repeat (8) @(negedge clk_sys);
    frame('{8'h14, 8'h00, 8'h00});
    check("confstr_restart", 128'({rx_q[1], rx_q[2]}), 128'(16'h4142));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
